// File: rtl/mem_stage_if.sv
// Data-memory port bundle between the MEM stage (master) and the data memory (slave).
// The master issues dm_req/dm_we/dm_addr/dm_be/dm_wdata and holds them until dm_gnt.
// Read data returns later on dm_rvalid/dm_rdata.
interface mem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline.
// Issues loads/stores on the data-memory port, stalls upstream while an access
// is outstanding, and registers the MEM/WB bundle with load data already
// extended and lane-aligned.
//
// memop encoding (mem_i_memop, 4 bits):
//   0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 behave as NONE.
//
// Optional feature: define MEM_ALIGN_CHECK_EN to trap misaligned halfword/word
// accesses (no request, no stall, exception flag in the bundle). Without it the
// exception outputs are tied low and misaligned addresses are truncated.
//
// DM_TIMEOUT > 0 aborts an access after that many cycles in REQ/RESP; the
// aborted result reaches WB with mem_o_rfwe cleared.
module mem_stage #(
  parameter int unsigned DM_TIMEOUT = 0
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        mem_i_dm2rf,
  input  logic        mem_i_hilowe,
  input  logic        mem_i_rfwe,
  input  logic [4:0]  mem_i_rfwa,
  input  logic [63:0] mem_i_mulres,
  input  logic [31:0] mem_i_alures,
  input  logic [31:0] mem_i_dmdin,
  input  logic [3:0]  mem_i_memop,
  output logic        mem_stall,
  mem_stage_if.master dm,
  output logic        mem_o_rfwe,
  output logic [4:0]  mem_o_rfwa,
  output logic [31:0] mem_o_wd,
  output logic        mem_o_hilowe,
  output logic [63:0] mem_o_mulres,
  output logic        mem_o_exc_adel,
  output logic        mem_o_exc_ades
);

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Byte enables for the addressed lanes; loads use the same lanes they read.
  function automatic logic [3:0] lane_be(input logic [3:0] op, input logic [1:0] lo);
    logic [3:0] be;
    case (op)
      OP_LB, OP_LBU, OP_SB: be = 4'b0001 << lo;
      OP_LH, OP_LHU, OP_SH: be = lo[1] ? 4'b1100 : 4'b0011;
      default:              be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across lanes so the memory only has to honour dm_be.
  function automatic logic [31:0] lane_wdata(input logic [3:0] op, input logic [31:0] d);
    logic [31:0] w;
    case (op)
      OP_SB:   w = {4{d[7:0]}};
      OP_SH:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Select the addressed lane from a read word and sign/zero-extend it.
  function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [1:0] lo,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'h0, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  state_e      state_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [1:0]  lo_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [3:0]  op_q;
  logic        rfwe_lat_q;
  logic [4:0]  rfwa_lat_q;
  logic        dm2rf_lat_q;
  logic [31:0] ldata_q;
  logic        abort_q;
  logic [31:0] tmo_q;

  logic        is_load_d;
  logic        is_store_d;
  logic        misal_d;
  logic        issue_d;
  logic        tmo_hit_d;

  // Classify the op currently held in the EX/MEM register.
  always_comb begin
    is_load_d  = 1'b0;
    is_store_d = 1'b0;
    case (mem_i_memop)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: is_load_d  = 1'b1;
      OP_SB, OP_SH, OP_SW:                 is_store_d = 1'b1;
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misal_d = (((mem_i_memop == OP_LH) || (mem_i_memop == OP_LHU) || (mem_i_memop == OP_SH))
                    && mem_i_alures[0])
                || (((mem_i_memop == OP_LW) || (mem_i_memop == OP_SW))
                    && (mem_i_alures[1:0] != 2'b00));
`else
  assign misal_d = 1'b0;
`endif

  assign issue_d   = (is_load_d || is_store_d) && !misal_d;
  assign tmo_hit_d = (DM_TIMEOUT != 0) && (tmo_q == DM_TIMEOUT - 1);
  assign mem_stall = ((state_q == S_IDLE) && issue_d) || (state_q == S_REQ) || (state_q == S_RESP);

  assign dm.dm_req   = req_q;
  assign dm.dm_we    = we_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_be    = be_q;
  assign dm.dm_wdata = wdata_q;

  // Access FSM: latch the request in IDLE, hold it through REQ, capture read data in RESP.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      lo_q        <= 2'b00;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
      op_q        <= OP_NONE;
      rfwe_lat_q  <= 1'b0;
      rfwa_lat_q  <= 5'h0;
      dm2rf_lat_q <= 1'b0;
      ldata_q     <= 32'h0;
      abort_q     <= 1'b0;
      tmo_q       <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue_d) begin
            state_q     <= S_REQ;
            req_q       <= 1'b1;
            we_q        <= is_store_d;
            addr_q      <= {mem_i_alures[31:2], 2'b00};
            lo_q        <= mem_i_alures[1:0];
            be_q        <= lane_be(mem_i_memop, mem_i_alures[1:0]);
            wdata_q     <= lane_wdata(mem_i_memop, mem_i_dmdin);
            op_q        <= mem_i_memop;
            rfwe_lat_q  <= mem_i_rfwe;
            rfwa_lat_q  <= mem_i_rfwa;
            dm2rf_lat_q <= mem_i_dm2rf;
            abort_q     <= 1'b0;
            tmo_q       <= 32'h0;
          end
        end
        S_REQ: begin
          if (dm.dm_gnt) begin
            req_q   <= 1'b0;
            state_q <= we_q ? S_DONE : S_RESP;
            tmo_q   <= tmo_q + 32'd1;
          end else if (tmo_hit_d) begin
            req_q   <= 1'b0;
            abort_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        S_RESP: begin
          if (dm.dm_rvalid) begin
            ldata_q <= load_extend(op_q, lo_q, dm.dm_rdata);
            state_q <= S_DONE;
          end else if (tmo_hit_d) begin
            abort_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        default: begin
          // DONE lasts one cycle; the op still on the inputs has already been served.
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // MEM/WB bundle: bubble while stalled, latched access result in DONE, pass-through otherwise.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      mem_o_rfwe   <= 1'b0;
      mem_o_rfwa   <= 5'h0;
      mem_o_wd     <= 32'h0;
      mem_o_hilowe <= 1'b0;
      mem_o_mulres <= 64'h0;
    end else if (mem_stall) begin
      mem_o_rfwe   <= 1'b0;
      mem_o_hilowe <= 1'b0;
    end else if (state_q == S_DONE) begin
      mem_o_rfwe   <= rfwe_lat_q && !abort_q;
      mem_o_rfwa   <= rfwa_lat_q;
      mem_o_wd     <= dm2rf_lat_q ? ldata_q : mem_i_alures;
      mem_o_hilowe <= mem_i_hilowe;
      mem_o_mulres <= mem_i_mulres;
    end else begin
      mem_o_rfwe   <= mem_i_rfwe && !(misal_d && is_load_d);
      mem_o_rfwa   <= mem_i_rfwa;
      mem_o_wd     <= mem_i_alures;
      mem_o_hilowe <= mem_i_hilowe;
      mem_o_mulres <= mem_i_mulres;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  // Address-error flags travel with the bundle of the trapped op only.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      mem_o_exc_adel <= 1'b0;
      mem_o_exc_ades <= 1'b0;
    end else if (mem_stall || (state_q == S_DONE)) begin
      mem_o_exc_adel <= 1'b0;
      mem_o_exc_ades <= 1'b0;
    end else begin
      mem_o_exc_adel <= misal_d && is_load_d;
      mem_o_exc_ades <= misal_d && is_store_d;
    end
  end
`else
  assign mem_o_exc_adel = 1'b0;
  assign mem_o_exc_ades = 1'b0;
`endif

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS pipeline. It consumes the EX/MEM pipeline-register outputs (`mem_i_*`), runs loads and stores against the data-memory port with a request/grant/response handshake, and stalls the upstream pipeline while an access is outstanding. It drives a registered MEM/WB bundle (`mem_o_*`) with load data already extended and aligned.

## Interface
Parameters:
- `DM_TIMEOUT`, 0: cycles to wait in REQ/RESP before aborting; 0 disables the timeout.

Ports:
- `cpu_clk_50M`  in  1  clock.
- `cpu_rst`  in  1  asynchronous, active-high reset.
- `mem_i_dm2rf`  in  1  result comes from data memory.
- `mem_i_hilowe`  in  1  HI/LO write enable.
- `mem_i_rfwe`  in  1  register-file write enable.
- `mem_i_rfwa`  in  5  register-file write address.
- `mem_i_mulres`  in  64  multiply result.
- `mem_i_alures`  in  32  ALU result; this is the effective address for memory ops.
- `mem_i_dmdin`  in  32  store data.
- `mem_i_memop`  in  memop  one of NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
- `mem_stall`  out  1  holds the EX/MEM register and all earlier stages.
- `dm_req`  out  1  memory request.
- `dm_we`  out  1  1 = write.
- `dm_addr`  out  32  word-aligned address ({addr[31:2],2'b00}).
- `dm_be`  out  4  byte enables, little-endian.
- `dm_wdata`  out  32  write data, lane-replicated.
- `dm_gnt`  in  1  request accepted.
- `dm_rvalid`  in  1  read data valid.
- `dm_rdata`  in  32  read data.
- `mem_o_rfwe`, `mem_o_rfwa`(5), `mem_o_wd`(32), `mem_o_hilowe`, `mem_o_mulres`(64)  out  registered MEM/WB bundle.
- `mem_o_exc_adel`, `mem_o_exc_ades`  out  1  misaligned load / store flags (registered).

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- **IDLE**
  - memop NONE: no stall. The bundle loads the pass-through values at the next edge; `mem_o_wd` = alures.
  - Valid load/store: latch address, op, rfwa, be and wdata. Go to REQ. `mem_stall`=1.
- **REQ**
  - `dm_req`=1, and `dm_we`/`dm_addr`/`dm_be`/`dm_wdata` come from the latched values and stay stable until grant.
  - On `dm_gnt`: a store goes to DONE; a load goes to RESP.
- **RESP**: on `dm_rvalid`, capture extended data and go to DONE. `dm_rvalid` in any other state is ignored.
- **DONE**
  - `mem_stall`=0; return to IDLE unconditionally. The still-present `mem_i_memop` is not re-issued.
  - The bundle loads the latched result.
- `mem_stall` = (state==IDLE && valid memop) || state==REQ || state==RESP.
- Bundle update rules:
  - Any cycle with `mem_stall`=1: `mem_o_rfwe` and `mem_o_hilowe` are loaded with 0 (bubble).
  - Otherwise: computed values are loaded.
- Byte lanes come from addr[1:0].
  - SB: be = 1<<addr[1:0], wdata = {4{dmdin[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{dmdin[15:0]}}.
  - SW: be = 1111.
- Load extension:
  - LB/LH sign-extend the selected lane.
  - LBU/LHU zero-extend it.
  - LW passes the word unchanged.
- Timeout (`DM_TIMEOUT`>0): after `DM_TIMEOUT` cycles in REQ/RESP, go to DONE with `mem_o_rfwe`=0.

## Timing
- Reset value of every output is 0, and the FSM resets to IDLE. Reset mid-access drops the request; a late `dm_rvalid` after reset is ignored.
- Non-memory ops: 1-cycle latency, zero stall.
- Store with immediate grant: stall cycles C0 (IDLE) and C1 (REQ+gnt). DONE in C2; bundle valid after the C2 edge.
- Load with immediate grant and `dm_rvalid` in the next cycle: stall cycles C0, C1, C2. DONE in C3; data visible after the C3 edge.
- The responder must not assert `dm_rvalid` in the same cycle as `dm_gnt`.
- Extra wait cycles on `dm_gnt`/`dm_rvalid` extend the stall one for one.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - LH/LHU with addr[0]≠0 and LW with addr[1:0]≠0 issue no request and cause no stall. They set `mem_o_exc_adel`=1 with `mem_o_rfwe`=0.
  - Stores with the same conditions set `mem_o_exc_ades`=1.
- Undefined:
  - The exception outputs are tied to 0.
  - Misaligned addresses are silently truncated: halfword uses addr[1] only, word uses addr[31:2].

## Test plan
- ADD-style op (memop NONE, alures=0x1234, rfwe=1, rfwa=5): no stall; one cycle later `mem_o_wd`=0x1234, `mem_o_rfwa`=5, `mem_o_rfwe`=1.
- SB addr=0x103, dmdin=0xAB, immediate gnt: `dm_be`=1000, `dm_wdata`=0xABABABAB, `dm_addr`=0x100; `mem_stall` high for exactly 2 cycles.
- LB addr=0x102, rdata=0x0080_0000 after a 3-cycle gnt delay: `mem_o_wd`=0xFFFFFF80. LBU at the same address gives 0x00000080. The stall lasts 2+3+1 cycles.
- LHU addr=0x102, rdata=0xBEEF1234: `mem_o_wd`=0x0000BEEF. LW addr=0x102 with the macro on: `mem_o_exc_adel`=1, `dm_req` never asserted.
- Assert `cpu_rst` while in RESP, then pulse `dm_rvalid`: outputs stay 0 and the FSM is in IDLE.
- Back-to-back SW then LW: each access is issued exactly once. Bubble `mem_o_rfwe`=0 on stall cycles, and there is no duplicate request in DONE.
